// File: rtl/button_conditioner.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM and a single-cycle
// change-light request, with a saturating count of presses rejected during lockout.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       lockout,
    input  logic       buttonRaw,
    output logic       buttonPulse,
    output logic       buttonLevel,
    output logic [7:0] ignoredCount
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_pulse;
    logic                 r_level;
    logic [7:0]           r_ignored;

    state_t               w_state_next;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic                 w_level_next;
    logic                 w_accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= buttonRaw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_level <= w_level_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_level_next = r_level;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_state_next = PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!r_sync2) begin
                    w_state_next = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = HELD;
                    w_level_next = 1'b1;
                    w_accept     = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!r_sync2) begin
                    w_state_next = RELEASE_WAIT;
                    w_cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A high sample here is release bounce: back to HELD without a new request.
                if (r_sync2) begin
                    w_state_next = HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = IDLE;
                    w_level_next = 1'b0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
                w_level_next = 1'b0;
            end
        endcase
    end

    // enable/lockout matter only on the acceptance edge; a lockout ending later never pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pulse   <= 1'b0;
            r_ignored <= 8'd0;
        end else begin
            r_pulse <= w_accept & enable & ~lockout;
            if (w_accept && enable && lockout && (r_ignored != 8'hFF)) begin
                r_ignored <= r_ignored + 8'd1;
            end
        end
    end

    assign buttonPulse  = r_pulse;
    assign buttonLevel  = r_level;
    assign ignoredCount = r_ignored;

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the raw manual-mode push-button for the traffic-light controller. Synchronizes, debounces and edge-detects the raw input and issues a single-cycle change-light request to the manual-mode sequencer. Suppresses requests while the sequencer is mid-yellow (`lockout`) or manual mode is off (`enable`). Counts presses rejected during lockout for status display. Sits directly upstream of the manual-mode sequencer and drives its change-light input.

## Interface
- `DEBOUNCE_CYCLES`, default 4: number of consecutive stable synchronized samples required to accept a press or a release; legal range ≥ 2. Board build overrides it, e.g. 500000 at 50 MHz.
- `CNT_WIDTH`, default 20: debounce counter width; must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.
- `clk`, input, 1: single system clock, rising edge.
- `reset`, input, 1: asynchronous, active-low; 0 resets all state immediately.
- `enable`, input, 1: manual mode active; when 0, `buttonPulse` is never asserted.
- `lockout`, input, 1: high while the sequencer is in a yellow phase (YR/RY); accepted presses are rejected and counted.
- `buttonRaw`, input, 1: asynchronous raw button, active-high, may bounce.
- `buttonPulse`, output, 1: one-cycle change-light request, registered.
- `buttonLevel`, output, 1: debounced button level, registered.
- `ignoredCount`, output, 8: presses rejected by `lockout`; saturates at 255.

## Operation
- **Synchronizer:** 2-flop chain `sync1` → `sync2` on `buttonRaw`. The FSM uses only `sync2`.
- **FSM states:** IDLE, PRESS_WAIT, HELD, RELEASE_WAIT. Counter `cnt` is CNT_WIDTH bits.
- **IDLE:**
  - `sync2`=1 → PRESS_WAIT, `cnt`←0.
- **PRESS_WAIT:**
  - `sync2`=0 → IDLE (bounce rejected).
  - Else if `cnt`==DEBOUNCE_CYCLES-1 → HELD, `buttonLevel`←1, press accepted.
  - Else `cnt`←`cnt`+1.
- **Press accepted** (on the PRESS_WAIT→HELD edge, sampled that same edge):
  - `enable`=1 and `lockout`=0 → `buttonPulse`←1 for exactly one cycle.
  - `enable`=1 and `lockout`=1 → no pulse; `ignoredCount`←`ignoredCount`+1, unless already 255.
  - `enable`=0 → no pulse, no count.
- **HELD:**
  - `sync2`=0 → RELEASE_WAIT, `cnt`←0.
  - Holding the button never produces another pulse; there is no auto-repeat.
- **RELEASE_WAIT:**
  - `sync2`=1 → HELD (release bounce rejected; no new pulse).
  - Else if `cnt`==DEBOUNCE_CYCLES-1 → IDLE, `buttonLevel`←0.
  - Else `cnt`←`cnt`+1.
- **Other encodings:** undefined state encodings → IDLE.
- **Pulse clearing:** `buttonPulse` is cleared on every edge where no press is accepted.
- **`lockout` / `enable` timing:** both are sampled only at the acceptance edge. A lockout that ends while the button is HELD does not retroactively generate a pulse.

## Timing
- **Reset values** (`reset`=0): `sync1`=`sync2`=0, state IDLE, `cnt`=0, `buttonPulse`=0, `buttonLevel`=0, `ignoredCount`=0.
- **Reset mid-operation:** a press in progress is discarded. After release of reset, a still-held button must pass the full debounce again and then produces one pulse.
- **Press latency:** `buttonRaw` first sampled high at edge N and held stable:
  - `sync2`=1 after edge N+1.
  - PRESS_WAIT entered at edge N+2.
  - `buttonPulse`/`buttonLevel` rise at edge N+DEBOUNCE_CYCLES+2.
- **Release latency:** same as press latency; `buttonLevel` falls DEBOUNCE_CYCLES+2 edges after the first low sample.
- **Minimum press:** a high glitch shorter than DEBOUNCE_CYCLES+1 synchronized cycles produces neither a pulse nor a `buttonLevel` change.
- **Pulse width:** exactly 1 clk. Minimum spacing between pulses is 2·(DEBOUNCE_CYCLES+1) cycles.

## Test plan
- **Clean press:** DEBOUNCE_CYCLES=4, `enable`=1, `lockout`=0; `buttonRaw` high from edge 10 for 20 cycles → `buttonPulse`=1 only in the cycle after edge 16; `buttonLevel` rises at edge 16 and falls 6 edges after the first low sample.
- **Bounce:** toggle `buttonRaw` 1/0 every 2 cycles for 20 cycles, then hold high → exactly one pulse, 6 edges after the final rise; `ignoredCount`=0.
- **Lockout:** `lockout`=1 during three separate clean presses → no pulse, `ignoredCount`=3. Then `lockout`=0 and one press → one pulse, count stays 3.
- **Saturation / enable:** 260 presses under `lockout` → `ignoredCount`=255. With `enable`=0, a press → no pulse and count unchanged.
- **Long hold:** hold the button 100 cycles → one pulse only. Release with a 2-cycle re-bounce → no extra pulse.
- **Async reset:** drive `reset`=0 mid-PRESS_WAIT, between clock edges → outputs 0 immediately. Release `reset` with the button still held → one pulse DEBOUNCE_CYCLES+2 edges after the first sample.
